// File: rtl/dual_counter_pkg.sv
// Shared widths, initial values and run/stop state type for dual_counter.
// DUAL_COUNTER_BCD_EN selects decimal (0-9) instead of binary (0-F) counters.
package dual_counter_pkg;

    localparam int unsigned CNT_W = 4;

    localparam logic [CNT_W-1:0] CNT1_INIT = '0;

`ifdef DUAL_COUNTER_BCD_EN
    localparam logic [CNT_W-1:0] CNT_MAX = 4'd9;
`else
    localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;
`endif

    localparam logic [CNT_W-1:0] CNT2_INIT = CNT_MAX;

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/dual_counter_tick_gen.sv
// Prescaler producing a one-cycle TICK every PRESCALE enabled cycles.
// Holds its count while EN is low; CLR and RST return it to zero.
module tick_gen #(
    parameter int unsigned PRESCALE = 50000000,
    parameter int unsigned PW       = 26
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    input  logic CLR,
    output logic TICK
);

    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre;

    assign TICK = EN && (pre == LAST);

    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            pre <= '0;
        end else if (EN) begin
            pre <= (pre == LAST) ? '0 : pre + 1'b1;
        end
    end

endmodule

// File: rtl/dual_counter.sv
// Up/down counter pair advanced by a prescaled tick, gated by a BTN start/stop FSM.
// Build option: DUAL_COUNTER_BCD_EN makes both counters decimal.
module dual_counter
    import dual_counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 50000000,
    parameter int unsigned PW       = 26
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             BTN,
    input  logic             CLR,
    output logic [CNT_W-1:0] CNT1,
    output logic [CNT_W-1:0] CNT2,
    output logic             CO1,
    output logic             BO2,
    output logic             RUN
);

    state_t           state;
    logic             btn_q;
    logic             tick;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;
    logic             co1;
    logic             bo2;

    tick_gen #(
        .PRESCALE (PRESCALE),
        .PW       (PW)
    ) u_tick_gen (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (state == ST_RUN),
        .CLR  (CLR),
        .TICK (tick)
    );

    // A tick coincident with a BTN edge still uses the pre-toggle state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_STOP;
            btn_q <= 1'b0;
            cnt1  <= CNT1_INIT;
            cnt2  <= CNT2_INIT;
            co1   <= 1'b0;
            bo2   <= 1'b0;
        end else begin
            btn_q <= BTN;
            if (BTN && !btn_q) begin
                state <= (state == ST_RUN) ? ST_STOP : ST_RUN;
            end

            if (CLR) begin
                cnt1 <= CNT1_INIT;
                cnt2 <= CNT2_INIT;
                co1  <= 1'b0;
                bo2  <= 1'b0;
            end else begin
                co1 <= tick && (cnt1 == CNT_MAX);
                bo2 <= tick && (cnt2 == '0);
                if (tick) begin
                    cnt1 <= (cnt1 == CNT_MAX) ? '0 : cnt1 + 1'b1;
                    cnt2 <= (cnt2 == '0) ? CNT_MAX : cnt2 - 1'b1;
                end
            end
        end
    end

    assign CNT1 = cnt1;
    assign CNT2 = cnt2;
    assign CO1  = co1;
    assign BO2  = bo2;
    assign RUN  = (state == ST_RUN);

endmodule
